decode_stage: RTL

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 120 ++++++++++++
 1 files changed

// File: rtl/decode_stage.sv
// Decode stage for a minimal RV32I subset (ADD, ADDI).
// Holds the 32-entry register file, decodes one instruction per accept and
// presents registered operands to the ALU behind a valid/ready handshake.
// Unsupported instructions are consumed and flagged with a one-cycle pulse.
module decode_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic        wb_en,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] op1,
    output logic [31:0] op2,
    output logic        is_add,
    output logic        is_addi,
    output logic [4:0]  rd,
    output logic        illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    logic [31:0] regs [32];

    logic [6:0]  f_opcode;
    logic [4:0]  f_rd;
    logic [2:0]  f_funct3;
    logic [4:0]  f_rs1;
    logic [4:0]  f_rs2;
    logic [6:0]  f_funct7;

    logic        dec_add;
    logic        dec_addi;
    logic        dec_legal;
    logic        accept;
    logic        consume;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm_val;

    assign f_opcode = instr[6:0];
    assign f_rd     = instr[11:7];
    assign f_funct3 = instr[14:12];
    assign f_rs1    = instr[19:15];
    assign f_rs2    = instr[24:20];
    assign f_funct7 = instr[31:25];

    assign dec_add   = (f_opcode == OPC_OP) && (f_funct3 == 3'b000) && (f_funct7 == 7'b0000000);
    assign dec_addi  = (f_opcode == OPC_OP_IMM) && (f_funct3 == 3'b000);
    assign dec_legal = dec_add || dec_addi;
    assign imm_val   = {{20{instr[31]}}, instr[31:20]};

    // The stage can take a new instruction whenever its output slot is empty or being drained.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign consume  = out_valid && out_ready;

    // Operand read: x0 is hardwired to zero, and a writeback landing this cycle is forwarded.
    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        if (f_rs1 != 5'd0) begin
            if (wb_en && (wb_rd == f_rs1)) begin
                rs1_val = wb_data;
            end else begin
                rs1_val = regs[f_rs1];
            end
        end
        if (f_rs2 != 5'd0) begin
            if (wb_en && (wb_rd == f_rs2)) begin
                rs2_val = wb_data;
            end else begin
                rs2_val = regs[f_rs2];
            end
        end
    end

    // Register file writeback runs regardless of any output stall; writes to x0 are dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en && (wb_rd != 5'd0)) begin
            regs[wb_rd] <= wb_data;
        end
    end

    // Output slot: load on a legal accept, empty on drain, otherwise hold; illegal pulses once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            op1       <= '0;
            op2       <= '0;
            is_add    <= 1'b0;
            is_addi   <= 1'b0;
            rd        <= '0;
            illegal   <= 1'b0;
        end else begin
            illegal <= accept && !dec_legal;
            if (accept && dec_legal) begin
                out_valid <= 1'b1;
                op1       <= rs1_val;
                op2       <= dec_add ? rs2_val : imm_val;
                is_add    <= dec_add;
                is_addi   <= dec_addi;
                rd        <= f_rd;
            end else if (consume) begin
                out_valid <= 1'b0;
                is_add    <= 1'b0;
                is_addi   <= 1'b0;
            end
        end
    end

endmodule
